uart_tx: RTL and testbench

- UART transmitter: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
- Bytes enter through a valid/ready interface and are buffered in an internal FIFO.
- Frames are serialised on uart_txd back-to-back, with no idle gap while data is queued.
- Counterpart of the UART receiver; the two share the same BPS/CLK_FRE parameterisation.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 82 ++++++++
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter and receiver: the FSM state
// encoding, the frame shape, and the per-bit clock count derived from the
// BPS / CLK_FRE parameter pair.
package uart_pkg;

  // Frame shape: 1 start bit, DATA_BITS data bits (LSB first), STOP_BITS stop bits.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // sys_clk cycles per bit period (integer division, truncating).
  function automatic int calc_bps_cnt(input int clk_fre, input int bps);
    return clk_fre / bps;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous single-clock FIFO buffering bytes for the UART transmitter.
// Read data is show-ahead: rd_data shows the oldest entry whenever !empty.
//
// A freshly written entry becomes visible to the reader one cycle after the
// write edge. This gives the transmitter a fixed two-edge accept-to-start
// latency. full and level track the real write pointer, so occupancy and
// back-pressure update on the edge right after a write.
//
// Ports:
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset (clears pointers)
//   wr_en      in   write request (ignored while full)
//   wr_data    in   WIDTH-bit data to write
//   rd_en      in   pop request (ignored while empty)
//   rd_data    out  oldest entry, valid while !empty
//   full       out  DEPTH entries stored
//   empty      out  no entry visible to the reader
//   level      out  number of stored entries, 0..DEPTH
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      wr_vis_reg;   // write pointer as seen by the reader
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_write;
  logic             do_read;

  assign do_write = wr_en && !full;
  assign do_read  = rd_en && !empty;

  always_ff @(posedge sys_clk) begin
    if (do_write) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      wr_vis_reg <= '0;
    end else begin
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_read) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      wr_vis_reg <= wr_ptr_reg;
    end
  end

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_vis_reg == rd_ptr_reg);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// UART transmitter, 8N1, LSB first, idle-high line. Bytes are accepted over
// a valid/ready handshake into a FIFO. They are sent back-to-back with no
// idle gap while the FIFO holds data.
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   tx_data     in   byte to send, sampled on accept (tx_valid && tx_ready)
//   tx_valid    in   tx_data is valid
//   tx_ready    out  FIFO can take a byte (= !full)
//   uart_txd    out  registered serial line
//   tx_busy     out  FIFO non-empty or a frame in progress
//   fifo_level  out  queued bytes, excluding the one being shifted
module uart_tx
  import uart_pkg::*;
#(
  parameter int BPS        = 9_600,
  parameter int CLK_FRE    = 200_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FRE, BPS);
  localparam int BCW     = $clog2(DATA_BITS);
  localparam logic [15:0]    BPS_LAST  = 16'(BPS_CNT - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

  generate
    if (BPS_CNT < 2 || BPS_CNT > 65535) begin : g_bad_bps
      $error("uart_tx: CLK_FRE/BPS must lie in 2..65535");
    end
  endgenerate

  uart_state_t    state_reg, state_next;
  logic [15:0]    clk_cnt_reg, clk_cnt_next;
  logic [BCW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0]     shift_reg, shift_next;
  logic           txd_reg, txd_next;
  logic           pop;
  logic           bit_last;

  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_rd_data;
  logic           fifo_wr;

  assign tx_ready = !fifo_full;
  assign fifo_wr  = tx_valid && !fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (fifo_wr),
    .wr_data   (tx_data),
    .rd_en     (pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      txd_reg     <= 1'b1;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      txd_reg     <= txd_next;
    end
  end

  // Last cycle of the current bit period.
  assign bit_last = (clk_cnt_reg == BPS_LAST);

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    txd_next     = txd_reg;
    pop          = 1'b0;
    // The bit-period counter free-runs and wraps in every non-idle state.
    clk_cnt_next = bit_last ? 16'd0 : clk_cnt_reg + 16'd1;

    case (state_reg)
      IDLE: begin
        clk_cnt_next = 16'd0;
        txd_next     = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_rd_data;
          txd_next   = 1'b0;
          state_next = START;
        end
      end

      START: begin
        if (bit_last) begin
          state_next   = DATA;
          txd_next     = shift_reg[0];
          bit_cnt_next = '0;
        end
      end

      DATA: begin
        if (bit_last) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == DATA_LAST) begin
            state_next   = STOP;
            txd_next     = 1'b1;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            // shift_reg[1] becomes the LSB after this shift.
            txd_next     = shift_reg[1];
          end
        end
      end

      STOP: begin
        if (bit_last) begin
          if (bit_cnt_reg == STOP_LAST) begin
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_next = fifo_rd_data;
              txd_next   = 1'b0;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  assign uart_txd = txd_reg;
  assign tx_busy  = !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Directed bench for uart_tx at BPS_CNT = 10 (CLK_FRE=1 MHz, BPS=100 kbaud).
// A behavioural receiver decodes the line mid-bit into a byte queue.
module tb_uart_tx;

  localparam int CLK_FRE = 1_000_000;
  localparam int BPS     = 100_000;
  localparam int BC      = 10;
  localparam int DEPTH   = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic       uart_txd;
  logic       tx_busy;
  logic [4:0] fifo_level;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx #(
    .BPS        (BPS),
    .CLK_FRE    (CLK_FRE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  // Behavioural receiver: start detected on the first low sample, then
  // data bits are sampled at the centre of each bit period.
  logic [7:0] rx_q[$];
  int         rx_frame_err = 0;
  logic       rx_active    = 1'b0;
  int         rx_cnt       = 0;
  int         rx_n;
  int         rx_k;
  logic [7:0] rx_shift     = 8'h00;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_active <= 1'b0;
    end else if (rx_active) begin
      rx_n = rx_cnt + 1;
      rx_cnt <= rx_n;
      if (rx_n >= BC + BC / 2 && ((rx_n - BC / 2) % BC) == 0) begin
        rx_k = (rx_n - BC / 2) / BC;
        if (rx_k <= 8) begin
          rx_shift <= {uart_txd, rx_shift[7:1]};
        end else begin
          if (uart_txd !== 1'b1) rx_frame_err++;
          rx_q.push_back(rx_shift);
          rx_active <= 1'b0;
        end
      end
    end else if (uart_txd === 1'b0) begin
      rx_active <= 1'b1;
      rx_cnt    <= 0;
    end
  end

  int busy_cnt = 0;
  always @(negedge sys_clk) begin
    if (tx_busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; always returns on a falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_low(input int limit, output int waited);
    waited = 0;
    while (uart_txd !== 1'b0 && waited < limit) begin
      tick(1);
      waited++;
    end
  endtask

  task automatic wait_rx(input int n, input int limit);
    int w;
    w = 0;
    #1;
    while (rx_q.size() < n && w < limit) begin
      tick(1);
      #1;
      w++;
    end
  endtask

  // Called on the first sample of a start bit; checks all 10*BC samples.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [9:0] pat;
    int errs;
    pat  = {1'b1, b, 1'b0};
    errs = 0;
    for (int c = 0; c < 10 * BC; c++) begin
      if (uart_txd !== pat[c / BC]) errs++;
      tick(1);
    end
    check(tag, errs, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int lows;
    int idle_bad;

    // Reset state
    tick(3);
    #1;
    check("rst_txd", uart_txd, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_level", fifo_level, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick(1);

    // Idle hold
    idle_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (uart_txd !== 1'b1 || tx_ready !== 1'b1) idle_bad++;
      tick(1);
    end
    check("idle_hold", idle_bad, 0);

    // Single byte 0x55
    rx_q.delete();
    busy_cnt = 0;
    send(8'h55);
    check("single_level_n", fifo_level, 1);
    check("single_txd_n", uart_txd, 1);
    tick(1);
    check("single_txd_n1", uart_txd, 1);
    check("single_busy_n1", tx_busy, 1);
    tick(1);
    check("single_txd_n2", uart_txd, 0);
    check_frame(8'h55, "single_frame");
    check("single_end_txd", uart_txd, 1);
    check("single_end_busy", tx_busy, 0);
    check("single_end_level", fifo_level, 0);
    tick(2);
    #1;
    check("single_busy_cycles", busy_cnt, 101);
    check("single_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("single_rx_byte", rx_q[0], 8'h55);

    // Back-to-back 0xA5, 0x3C
    tick(5);
    rx_q.delete();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick(1);
    tx_data  = 8'h3C;
    tick(1);
    tx_valid = 1'b0;
    wait_low(20, w);
    check("b2b_latency", w, 1);
    check_frame(8'hA5, "b2b_frame_a5");
    check_frame(8'h3C, "b2b_frame_3c");
    check("b2b_end_txd", uart_txd, 1);
    check("b2b_end_busy", tx_busy, 0);

    // Loopback 0x00, 0xFF, 0x81
    tick(5);
    rx_q.delete();
    send(8'h00);
    send(8'hFF);
    send(8'h81);
    wait_rx(3, 600);
    check("loop_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("loop_byte0", rx_q[0], 8'h00);
      check("loop_byte1", rx_q[1], 8'hFF);
      check("loop_byte2", rx_q[2], 8'h81);
    end
    tick(20);

    // Overflow: 20 bytes offered, 17 accepted
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("ovf_ready_%0d", i), tx_ready, (i < 17) ? 1 : 0);
      tx_data  = 8'(8'h10 + i);
      tx_valid = 1'b1;
      tick(1);
    end
    tx_valid = 1'b0;
    check("ovf_level_full", fifo_level, 16);
    check("ovf_ready_low", tx_ready, 0);
    w = 0;
    while (tx_ready !== 1'b1 && w < 200) begin
      tick(1);
      w++;
    end
    check("ovf_ready_back", tx_ready, 1);
    check("ovf_level_15", fifo_level, 15);
    wait_rx(17, 2000);
    check("ovf_rx_count", rx_q.size(), 17);
    if (rx_q.size() == 17) begin
      for (int i = 0; i < 17; i++) begin
        check($sformatf("ovf_rx_byte_%0d", i), rx_q[i], 8'(8'h10 + i));
      end
    end
    tick(20);
    check("ovf_level_empty", fifo_level, 0);
    check("frame_errors", rx_frame_err, 0);

    // Reset during bit 3 of 0xF0, with 0x77 queued behind it
    rx_q.delete();
    send(8'hF0);
    send(8'h77);
    wait_low(20, w);
    check("rst_frame_start", w, 1);
    tick(45);
    check("rst_bit3_low", uart_txd, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst_async_txd", uart_txd, 1);
    check("rst_async_level", fifo_level, 0);
    tick(3);
    sys_rst_n = 1'b1;
    tick(1);
    check("rst_after_level", fifo_level, 0);
    check("rst_after_busy", tx_busy, 0);
    check("rst_after_ready", tx_ready, 1);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      if (uart_txd !== 1'b1) lows++;
      tick(1);
    end
    check("rst_no_frame", lows, 0);
    #1;
    check("rst_rx_empty", rx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
